c3lib_ckmux4_sel_ctrl: RTL
==========================

// Module: c3lib_ckmux4_sel_ctrl
// PURPOSE
//  Glitch-safe select sequencer for the c3lib 4:1 clock mux (s1/s0 inputs).
//  Accepts a requested source index and:
//  1. drops a downstream clock-gate enable,
//  2. waits GATE_CYC cycles,
//  3. updates s1/s0,
//  4. waits SETTLE_CYC cycles,
//  5. re-enables the gate.
//  Runs on an always-on reference clock; mux tst_* pins are tied off by the integrator.
// PARAMETERS
//  RST_SEL     2'b00  mux select value driven during/after reset
//  GATE_CYC    4      cycles in GATE_OFF before select changes (>=1)
//  SETTLE_CYC  8      cycles in SETTLE after select change (>=1)
//  CNT_W       local  $clog2(max(GATE_CYC,SETTLE_CYC)+1); not overridable
// PORTS
//  clk         in   1  always-on reference clock
//  rst_n       in   1  asynchronous active-low reset
//  sel_req     in   1  request strobe, sampled every cycle
//  sel_new     in   2  requested source {s1,s0}, valid with sel_req
//  sel_busy    out  1  1 when state != IDLE
//  sel_done    out  1  1-cycle pulse: requested source is live and gated on
//  sel_drop    out  1  1-cycle pulse: request discarded (see CONFIGURATION)
//  cur_sel     out  2  select currently driven to the mux
//  s0, s1      out  1  to mux s0/s1; always equal to cur_sel[0]/cur_sel[1]
//  ck_gate_en  out  1  enable for the clock gate after the mux output
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async assert):
//    - state=SETTLE, counter loaded with SETTLE_CYC-1.
//    - cur_sel=RST_SEL, ck_gate_en=0, sel_busy=1, sel_done=0, sel_drop=0.
//  - After reset release, the block sequences SETTLE then GATE_ON. The startup
//    GATE_ON cycle raises ck_gate_en but does NOT pulse sel_done.
//  - FSM states: IDLE, GATE_OFF, SWITCH, SETTLE, GATE_ON.
//  - IDLE, sel_req=1, sel_new != cur_sel:
//    - next state GATE_OFF, counter loaded with GATE_CYC-1.
//  - IDLE, sel_req=1, sel_new == cur_sel:
//    - stays in IDLE and pulses sel_done next cycle; no gating.
//  - GATE_OFF:
//    - ck_gate_en=0 and the counter decrements.
//    - At 0, goes to SWITCH.
//  - SWITCH (1 cycle):
//    - cur_sel<=target.
//    - Next state SETTLE, counter loaded with SETTLE_CYC-1.
//  - SETTLE: decrements the counter; at 0, goes to GATE_ON.
//  - GATE_ON (1 cycle): ck_gate_en=1, sel_done=1, next state IDLE.
//  - Timeline at defaults, request accepted in cycle 0:
//    - GATE_OFF in cycles 1-4; ck_gate_en low from cycle 1.
//    - SWITCH in cycle 5; s1/s0 change.
//    - SETTLE in cycles 6-13.
//    - GATE_ON in cycle 14: ck_gate_en=1 and sel_done=1.
//    - sel_busy=0 from cycle 15.
//  - Target is captured at acceptance; sel_new is ignored after that.
//  - sel_req is honoured only in IDLE. A request in any other state (including
//    the GATE_ON cycle and startup) is handled per CONFIGURATION.
//  - ck_gate_en never rises in a cycle where s1/s0 change.
//  - s1/s0 never change while ck_gate_en=1.
//  - Reset asserted mid-sequence: immediately returns to the reset values. Any
//    in-flight or pending request is lost; no sel_done is issued.
// CONFIGURATION
//  C3LIB_CKMUX4_SEL_CTRL_QUEUE_EN
//  - Defined:
//    - A one-deep pending slot captures any request arriving while busy.
//    - A later busy request overwrites the slot (newest wins) and pulses
//      sel_drop for the overwritten one.
//    - On entering IDLE, the pending request is replayed exactly as a fresh
//      IDLE request in that cycle; an external sel_req in the same cycle is
//      treated as busy (pending wins, the external request goes to the slot).
//  - Undefined:
//    - A request while busy is discarded and sel_drop pulses the next cycle.
//    - No pending slot logic is present.
// STRUCTURE
//  - Package c3lib_ckmux4_sel_ctrl_pkg:
//    - typedef enum logic [2:0] ckmux_st_e {IDLE,GATE_OFF,SWITCH,SETTLE,GATE_ON}.
//    - typedef logic [1:0] ckmux_sel_t.
//  - Single module; down-counter and pending slot inline; no sub-module.
//  - Bench instantiates c3lib_ckmux4_ulvt_gate (BEHAVIORAL) with tst_override=0.
// TESTING
//  - Reset release, RST_SEL=2'b10: s1s0=10 throughout; ck_gate_en 0 until SETTLE_CYC
//    cycles elapse, then 1; sel_done never pulses.
//  - Idle, sel_req with sel_new=01 from 00: ck_gate_en 0 in cycles 1-13; s0=1 at
//    cycle 5; ck_gate_en=1 and sel_done at cycle 14; mux ck_out == ck1.
//  - sel_req with sel_new==cur_sel: sel_done next cycle; ck_gate_en stays 1;
//    sel_busy stays 0.
//  - Request 11 at cycle 7 of an active switch:
//    - QUEUE_EN off: sel_drop at cycle 8; cur_sel keeps the first target.
//    - QUEUE_EN on: second sequence starts at cycle 15; cur_sel=11 at cycle 20.
//  - rst_n pulsed low during SETTLE: cur_sel=RST_SEL and ck_gate_en=0 immediately;
//    no sel_done for the aborted request.
//  - Assertion, all random tests: s1/s0 change only when ck_gate_en=0, and
//    ck_gate_en=1 only after SETTLE_CYC stable-select cycles.

Source files
------------

// File: rtl/c3lib_ckmux4_sel_ctrl_pkg.sv
// Shared types for the c3lib 4:1 clock-mux select sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package c3lib_ckmux4_sel_ctrl_pkg;

   // Sequencer states: gate off, wait, switch select, let the mux settle, gate on.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GATE_OFF = 3'd1,
      SWITCH   = 3'd2,
      SETTLE   = 3'd3,
      GATE_ON  = 3'd4
   } ckmux_st_e;

   // Mux select, {s1,s0}.
   typedef logic [1:0] ckmux_sel_t;

endpackage

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// Glitch-safe select sequencer for the c3lib 4:1 clock mux: gate off, switch s1/s0, settle, gate on.
// Latency: GATE_CYC+SETTLE_CYC+2 cycles from an accepted request to sel_done (1 cycle if already selected).
// Backpressure: requests are taken only while idle; busy requests are dropped, or with
//               C3LIB_CKMUX4_SEL_CTRL_QUEUE_EN defined, held in a one-deep newest-wins slot.
//
// Ports:
//   clk         always-on reference clock
//   rst_n       asynchronous active-low reset
//   sel_req     request strobe, sampled every cycle
//   sel_new     requested source {s1,s0}, valid with sel_req
//   sel_busy    high whenever the sequencer is not idle
//   sel_done    1-cycle pulse: requested source is live and gated on
//   sel_drop    1-cycle pulse: a request was discarded
//   cur_sel     select currently driven to the mux
//   s0, s1      mux select pins, mirror cur_sel
//   ck_gate_en  enable for the clock gate after the mux output
module c3lib_ckmux4_sel_ctrl
   import c3lib_ckmux4_sel_ctrl_pkg::*;
#(
   parameter ckmux_sel_t RST_SEL    = 2'b00,
   parameter int         GATE_CYC   = 4,
   parameter int         SETTLE_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sel_req,
   input  logic [1:0] sel_new,
   output logic       sel_busy,
   output logic       sel_done,
   output logic       sel_drop,
   output logic [1:0] cur_sel,
   output logic       s0,
   output logic       s1,
   output logic       ck_gate_en
);

   localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

   ckmux_st_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   ckmux_sel_t       tgt, tgt_nxt;
   ckmux_sel_t       cur_sel_nxt;
   logic             startup, startup_nxt;
   logic             done_nxt, drop_nxt, gate_nxt, busy_nxt;

   // Request presented to the IDLE decision this cycle (external or replayed).
   logic             acc_vld;
   ckmux_sel_t       acc_sel;

`ifdef C3LIB_CKMUX4_SEL_CTRL_QUEUE_EN
   logic             pend_vld, pend_vld_nxt;
   ckmux_sel_t       pend_sel, pend_sel_nxt;
`endif

   assign s0 = cur_sel[0];
   assign s1 = cur_sel[1];

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tgt_nxt     = tgt;
      cur_sel_nxt = cur_sel;
      startup_nxt = startup;
      done_nxt    = 1'b0;
      drop_nxt    = 1'b0;
      acc_vld     = 1'b0;
      acc_sel     = sel_new;

`ifdef C3LIB_CKMUX4_SEL_CTRL_QUEUE_EN
      pend_vld_nxt = pend_vld;
      pend_sel_nxt = pend_sel;
      if (state == IDLE && pend_vld) begin
         // Pending request replays first; a same-cycle external request takes the slot.
         acc_vld      = 1'b1;
         acc_sel      = pend_sel;
         pend_vld_nxt = sel_req;
         if (sel_req) pend_sel_nxt = sel_new;
      end else if (state == IDLE) begin
         acc_vld = sel_req;
      end else if (sel_req) begin
         // Newest wins: an occupied slot is overwritten and its old request dropped.
         drop_nxt     = pend_vld;
         pend_vld_nxt = 1'b1;
         pend_sel_nxt = sel_new;
      end
`else
      acc_vld  = sel_req && (state == IDLE);
      drop_nxt = sel_req && (state != IDLE);
`endif

      case (state)
         IDLE: begin
            if (acc_vld) begin
               if (acc_sel != cur_sel) begin
                  state_nxt = GATE_OFF;
                  cnt_nxt   = GATE_LD;
                  tgt_nxt   = acc_sel;
               end else begin
                  done_nxt  = 1'b1;
               end
            end
         end
         GATE_OFF: begin
            if (cnt == '0) begin
               // Select is registered on entry so s1/s0 move in the SWITCH cycle.
               state_nxt   = SWITCH;
               cur_sel_nxt = tgt;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         SWITCH: begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LD;
         end
         SETTLE: begin
            if (cnt == '0) begin
               state_nxt = GATE_ON;
               // The post-reset gate-on is not the completion of any request.
               done_nxt  = !startup;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         GATE_ON: begin
            state_nxt   = IDLE;
            startup_nxt = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Gate is open only while idle or in GATE_ON; outputs follow the next state.
      gate_nxt = (state_nxt == IDLE) || (state_nxt == GATE_ON);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SETTLE;
         cnt        <= SETTLE_LD;
         tgt        <= RST_SEL;
         cur_sel    <= RST_SEL;
         startup    <= 1'b1;
         ck_gate_en <= 1'b0;
         sel_busy   <= 1'b1;
         sel_done   <= 1'b0;
         sel_drop   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         tgt        <= tgt_nxt;
         cur_sel    <= cur_sel_nxt;
         startup    <= startup_nxt;
         ck_gate_en <= gate_nxt;
         sel_busy   <= busy_nxt;
         sel_done   <= done_nxt;
         sel_drop   <= drop_nxt;
      end
   end

`ifdef C3LIB_CKMUX4_SEL_CTRL_QUEUE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld <= 1'b0;
         pend_sel <= RST_SEL;
      end else begin
         pend_vld <= pend_vld_nxt;
         pend_sel <= pend_sel_nxt;
      end
   end
`endif

endmodule
